// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Default word/address widths match the arbiter's parameter defaults.
package memory_arbiter_pkg;

  localparam int NUM_PORTS  = 2;
  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 32;

  typedef logic [0:0] port_id_t;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic                  we;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester handshake, response and shared-memory signals of the arbiter.
// slave = arbiter side; master = requesters plus the RwMemory instance.
interface memory_arbiter_if
  import memory_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);

  logic [NUM_PORTS-1:0]                 i_ReqValid;
  logic [NUM_PORTS-1:0]                 o_ReqReady;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] i_ReqAddr;
  logic [NUM_PORTS-1:0]                 i_ReqWrEnable;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] i_ReqWrData;
  logic [NUM_PORTS-1:0]                 o_RspValid;
  logic [DATA_WIDTH-1:0]                o_RspRdData;
  logic [ADDR_WIDTH-1:0]                o_MemAddr;
  logic                                 o_MemWrEnable;
  logic [DATA_WIDTH-1:0]                o_MemWrData;
  logic [DATA_WIDTH-1:0]                i_MemRdData;

  modport slave (
    input  i_ReqValid, i_ReqAddr, i_ReqWrEnable, i_ReqWrData, i_MemRdData,
    output o_ReqReady, o_RspValid, o_RspRdData, o_MemAddr, o_MemWrEnable, o_MemWrData
  );

  modport master (
    output i_ReqValid, i_ReqAddr, i_ReqWrEnable, i_ReqWrData, i_MemRdData,
    input  o_ReqReady, o_RspValid, o_RspRdData, o_MemAddr, o_MemWrEnable, o_MemWrData
  );

endinterface

// File: rtl/memory_arbiter_rr_arbiter.sv
// Two-way arbiter: valid vector in, one-hot grant out (combinational).
// MEMORY_ARBITER_ROUND_ROBIN_EN adds a last-grant register; otherwise port 0 wins every conflict.
module rr_arbiter
  import memory_arbiter_pkg::*;
(
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  input  logic                 i_Clock,
  input  logic                 i_Reset,
`endif
  input  logic [NUM_PORTS-1:0] req_vld,
  output logic [NUM_PORTS-1:0] gnt
);

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  // prio names the port that wins the next conflict, i.e. the one not granted last.
  port_id_t prio;

  always_comb begin
    gnt = req_vld;
    if (&req_vld) begin
      gnt = (prio == 1'b0) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      prio <= 1'b0;
    end else if (|gnt) begin
      prio <= ~gnt[1];
    end
  end
`else
  assign gnt = {req_vld[1] & ~req_vld[0], req_vld[0]};
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port RwMemory between two requesters; one access per cycle, response at T+2.
// Build option MEMORY_ARBITER_ROUND_ROBIN_EN selects round-robin conflicts (default: port 0 priority).
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  memory_arbiter_if.slave  bus
);

  typedef struct packed {
    logic                  valid;
    port_id_t              port;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
  } stage_a_t;

  logic [NUM_PORTS-1:0]  gnt;
  port_id_t              win;
  stage_a_t              stage_a;
  logic [NUM_PORTS-1:0]  rsp_vld;
  logic [DATA_WIDTH-1:0] rsp_dat;

  rr_arbiter u_arb (
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
`endif
    .req_vld (bus.i_ReqValid),
    .gnt     (gnt)
  );

  assign win = gnt[1];

  // Ready is held low during reset so no request is seen as accepted while the pipe is cleared.
  assign bus.o_ReqReady    = gnt & {NUM_PORTS{i_Reset}};
  assign bus.o_MemAddr     = stage_a.addr;
  assign bus.o_MemWrData   = stage_a.wdata;
  assign bus.o_MemWrEnable = stage_a.valid & stage_a.we;
  assign bus.o_RspValid    = rsp_vld;
  assign bus.o_RspRdData   = rsp_dat;

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      stage_a <= '0;
      rsp_vld <= '0;
      rsp_dat <= '0;
    end else begin
      stage_a.valid <= |gnt;
      stage_a.port  <= win;
      stage_a.addr  <= bus.i_ReqAddr[win];
      stage_a.we    <= bus.i_ReqWrEnable[win];
      stage_a.wdata <= bus.i_ReqWrData[win];
      rsp_vld       <= {NUM_PORTS{stage_a.valid}} & (NUM_PORTS'(1) << stage_a.port);
      // Writes are acknowledged with zero data.
      rsp_dat       <= (stage_a.valid && !stage_a.we) ? bus.i_MemRdData : '0;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed and random traffic against a transaction-level model
// of the grant rules, the 2-cycle response timing and the shared memory contents.
`timescale 1ns/1ps
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    int            acc;
    int            port;
    mem_req_t      req;
    logic [DW-1:0] rdata;
  } txn_t;

  logic i_Clock = 1'b0;
  logic i_Reset;
  always #5 i_Clock = ~i_Clock;

  memory_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .bus     (bus)
  );

  int unsigned salt;

  function automatic logic [DW-1:0] seed_val(int a);
    return (DW'(a) * 32'h9E37_79B1) ^ DW'(salt);
  endfunction

  // RwMemory stand-in: combinational read, write on the clock edge; unwritten words read a seed pattern.
  logic [DW-1:0] phys_mem [DEPTH];
  bit            phys_wr  [DEPTH];
  assign bus.i_MemRdData = phys_wr[bus.o_MemAddr] ? phys_mem[bus.o_MemAddr] : seed_val(int'(bus.o_MemAddr));
  always @(posedge i_Clock) begin
    if (bus.o_MemWrEnable === 1'b1) begin
      phys_mem[bus.o_MemAddr] <= bus.o_MemWrData;
      phys_wr[bus.o_MemAddr]  <= 1'b1;
    end
  end

  int            cyc      = 0;
  int            last_gnt = -1;
  int            n_cmp    = 0;
  int            n_bad    = 0;
  txn_t          pend[$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [1:0]    hv = 2'b00;
  mem_req_t      hreq [2];

  function automatic logic [1:0] exp_ready();
    logic [1:0] v;
    v = bus.i_ReqValid;
    if (i_Reset !== 1'b1) return 2'b00;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    if (v == 2'b11) return (last_gnt == 0) ? 2'b10 : 2'b01;
`else
    if (v == 2'b11) return 2'b01;
`endif
    return v;
  endfunction

  function automatic void exp_rsp(output logic [1:0] vld, output logic [DW-1:0] dat);
    vld = 2'b00;
    dat = '0;
    if (pend.size() > 0 && pend[0].acc == cyc - 2) begin
      vld[pend[0].port] = 1'b1;
      dat = pend[0].req.we ? '0 : pend[0].rdata;
    end
  endfunction

  task automatic load(int p, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    hv[p]          = 1'b1;
    hreq[p].addr   = a;
    hreq[p].we     = we;
    hreq[p].wdata  = d;
  endtask

  task automatic present();
    bus.i_ReqValid = hv;
    for (int p = 0; p < 2; p++) begin
      bus.i_ReqAddr[p]     = hreq[p].addr;
      bus.i_ReqWrEnable[p] = hreq[p].we;
      bus.i_ReqWrData[p]   = hreq[p].wdata;
    end
  endtask

  // Model step for the edge ending the current cycle, then move 1ns past that edge.
  task automatic advance(output logic [1:0] g);
    txn_t t;
    g = exp_ready();
    foreach (pend[i]) begin
      if (pend[i].acc == cyc - 1) begin
        if (pend[i].req.we) ref_mem[pend[i].req.addr] = pend[i].req.wdata;
        else                pend[i].rdata = ref_mem[pend[i].req.addr];
      end
    end
    if (pend.size() > 0 && pend[0].acc == cyc - 2) void'(pend.pop_front());
    if (g != 2'b00) begin
      t.acc   = cyc;
      t.port  = g[1] ? 1 : 0;
      t.req   = hreq[t.port];
      t.rdata = '0;
      pend.push_back(t);
      last_gnt = t.port;
      hv[t.port] = 1'b0;
    end
    @(posedge i_Clock);
    cyc++;
    #1;
  endtask

  task automatic apply_reset(int n);
    logic [1:0] g;
    i_Reset  = 1'b0;
    pend.delete();
    last_gnt = -1;
    hv       = 2'b00;
    present();
    repeat (n) advance(g);
    i_Reset  = 1'b1;
  endtask

  task automatic test_reset();
    logic [1:0]    g, ev;
    logic [DW-1:0] ed;
    load(0, 1'b0, 10'd20, '0);
    load(1, 1'b0, 10'd21, '0);
    present();
    i_Reset  = 1'b0;
    pend.delete();
    last_gnt = -1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_Clock);
      n_cmp++;
      if ({bus.o_ReqReady, bus.o_RspValid, bus.o_RspRdData, bus.o_MemAddr, bus.o_MemWrEnable, bus.o_MemWrData} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs @%0d: rdy=%b rsp=%b dat=%h addr=%h we=%b wd=%h want all 0", cyc, bus.o_ReqReady,
                 bus.o_RspValid, bus.o_RspRdData, bus.o_MemAddr, bus.o_MemWrEnable, bus.o_MemWrData);
      end
      advance(g);
    end
    i_Reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      present();
      @(negedge i_Clock);
      exp_rsp(ev, ed);
      if (k == 0) begin
        n_cmp++;
        if (bus.o_ReqReady !== 2'b01) begin
          n_bad++;
          $display("FAIL reset_release_ready: got %b want 01", bus.o_ReqReady);
        end
      end
      n_cmp++;
      if (bus.o_ReqReady !== exp_ready()) begin
        n_bad++;
        $display("FAIL reset ready @%0d: got %b want %b", cyc, bus.o_ReqReady, exp_ready());
      end
      n_cmp++;
      if (bus.o_RspValid !== ev || (ev != 2'b00 && bus.o_RspRdData !== ed)) begin
        n_bad++;
        $display("FAIL reset rsp @%0d: got %b/%h want %b/%h", cyc, bus.o_RspValid, bus.o_RspRdData, ev, ed);
      end
      advance(g);
    end
  endtask

  task automatic test_single_write_read();
    logic [1:0]    g, ev;
    logic [DW-1:0] ed;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) load(0, 1'b1, 10'd5, 32'h0000_00AA);
      if (k == 1) load(0, 1'b0, 10'd5, '0);
      present();
      @(negedge i_Clock);
      exp_rsp(ev, ed);
      n_cmp++;
      if (bus.o_ReqReady !== exp_ready()) begin
        n_bad++;
        $display("FAIL single ready @%0d: got %b want %b", cyc, bus.o_ReqReady, exp_ready());
      end
      n_cmp++;
      if (bus.o_RspValid !== ev || (ev != 2'b00 && bus.o_RspRdData !== ed)) begin
        n_bad++;
        $display("FAIL single rsp @%0d: got %b/%h want %b/%h", cyc, bus.o_RspValid, bus.o_RspRdData, ev, ed);
      end
      if (k == 2 || k == 3) begin
        n_cmp++;
        if (bus.o_RspValid !== 2'b01 || bus.o_RspRdData !== ((k == 2) ? 32'h0 : 32'hAA)) begin
          n_bad++;
          $display("FAIL single_fixed k=%0d: got %b/%h want 01/%h", k, bus.o_RspValid, bus.o_RspRdData,
                   (k == 2) ? 32'h0 : 32'hAA);
        end
      end
      advance(g);
    end
  endtask

  task automatic test_raw();
    logic [1:0]    g, ev;
    logic [DW-1:0] ed;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) load(1, 1'b1, 10'd7, 32'h0000_1234);
      if (k == 1) load(0, 1'b0, 10'd7, '0);
      present();
      @(negedge i_Clock);
      exp_rsp(ev, ed);
      n_cmp++;
      if (bus.o_ReqReady !== exp_ready()) begin
        n_bad++;
        $display("FAIL raw ready @%0d: got %b want %b", cyc, bus.o_ReqReady, exp_ready());
      end
      n_cmp++;
      if (bus.o_RspValid !== ev || (ev != 2'b00 && bus.o_RspRdData !== ed)) begin
        n_bad++;
        $display("FAIL raw rsp @%0d: got %b/%h want %b/%h", cyc, bus.o_RspValid, bus.o_RspRdData, ev, ed);
      end
      if (k == 3) begin
        n_cmp++;
        if (bus.o_RspValid !== 2'b01 || bus.o_RspRdData !== 32'h0000_1234) begin
          n_bad++;
          $display("FAIL raw_fixed: got %b/%h want 01/00001234", bus.o_RspValid, bus.o_RspRdData);
        end
      end
      advance(g);
    end
  endtask

  task automatic test_conflict();
    logic [1:0]    g, ev, pat;
    logic [DW-1:0] ed;
    int            n_p1 = 0;
    apply_reset(2);
    for (int k = 0; k < 13; k++) begin
      if (k < 6) begin
        for (int p = 0; p < 2; p++)
          if (!hv[p]) load(p, 1'(p), AW'(200 + 8 * k + p), DW'($urandom));
      end
      present();
      @(negedge i_Clock);
      exp_rsp(ev, ed);
      if (k < 6) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        pat = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
        pat = 2'b01;
`endif
        n_cmp++;
        if (bus.o_ReqReady !== pat) begin
          n_bad++;
          $display("FAIL conflict_pattern k=%0d: got %b want %b", k, bus.o_ReqReady, pat);
        end
        if (bus.o_ReqReady[1] === 1'b1) n_p1++;
      end
      n_cmp++;
      if (bus.o_ReqReady !== exp_ready()) begin
        n_bad++;
        $display("FAIL conflict ready @%0d: got %b want %b", cyc, bus.o_ReqReady, exp_ready());
      end
      n_cmp++;
      if (bus.o_RspValid !== ev || (ev != 2'b00 && bus.o_RspRdData !== ed)) begin
        n_bad++;
        $display("FAIL conflict rsp @%0d: got %b/%h want %b/%h", cyc, bus.o_RspValid, bus.o_RspRdData, ev, ed);
      end
      advance(g);
    end
    n_cmp++;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    if (n_p1 != 3) begin
`else
    if (n_p1 != 0) begin
`endif
      n_bad++;
      $display("FAIL conflict_p1_grants: got %0d", n_p1);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0]    g, ev;
    logic [DW-1:0] ed;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) load(0, 1'b1, 10'd3, 32'h0000_0055);
      present();
      @(negedge i_Clock);
      exp_rsp(ev, ed);
      n_cmp++;
      if (bus.o_RspValid !== ev || (ev != 2'b00 && bus.o_RspRdData !== ed)) begin
        n_bad++;
        $display("FAIL rstmid pre rsp @%0d: got %b/%h want %b/%h", cyc, bus.o_RspValid, bus.o_RspRdData, ev, ed);
      end
      advance(g);
    end
    load(0, 1'b1, 10'd3, 32'hDEAD_BEEF);
    present();
    advance(g);
    // The write now sits in stage A; reset drops it.
    i_Reset  = 1'b0;
    pend.delete();
    last_gnt = -1;
    present();
    @(negedge i_Clock);
    n_cmp++;
    if ({bus.o_RspValid, bus.o_MemWrEnable} !== 3'b000) begin
      n_bad++;
      $display("FAIL rstmid_during: rsp=%b we=%b want 00/0", bus.o_RspValid, bus.o_MemWrEnable);
    end
    advance(g);
    i_Reset = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 3) load(0, 1'b0, 10'd3, '0);
      present();
      @(negedge i_Clock);
      exp_rsp(ev, ed);
      n_cmp++;
      if (bus.o_RspValid !== ev || (ev != 2'b00 && bus.o_RspRdData !== ed)) begin
        n_bad++;
        $display("FAIL rstmid rsp @%0d: got %b/%h want %b/%h", cyc, bus.o_RspValid, bus.o_RspRdData, ev, ed);
      end
      if (k < 3 || k == 5) begin
        n_cmp++;
        if (bus.o_RspValid !== ((k == 5) ? 2'b01 : 2'b00) || (k == 5 && bus.o_RspRdData !== 32'h0000_0055)) begin
          n_bad++;
          $display("FAIL rstmid_fixed k=%0d: got %b/%h", k, bus.o_RspValid, bus.o_RspRdData);
        end
      end
      advance(g);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]    g, ev, want;
    logic [DW-1:0] ed;
    int            n_rsp = 0;
    for (int k = 0; k < 11; k++) begin
      if (k < 8) load(k % 2, 1'b0, AW'(100 + k), '0);
      present();
      @(negedge i_Clock);
      exp_rsp(ev, ed);
      if (bus.o_RspValid !== 2'b00) n_rsp++;
      n_cmp++;
      if (bus.o_ReqReady !== exp_ready()) begin
        n_bad++;
        $display("FAIL b2b ready @%0d: got %b want %b", cyc, bus.o_ReqReady, exp_ready());
      end
      n_cmp++;
      if (bus.o_RspValid !== ev || (ev != 2'b00 && bus.o_RspRdData !== ed)) begin
        n_bad++;
        $display("FAIL b2b rsp @%0d: got %b/%h want %b/%h", cyc, bus.o_RspValid, bus.o_RspRdData, ev, ed);
      end
      if (k >= 2 && k <= 9) begin
        want = (k % 2 == 0) ? 2'b01 : 2'b10;
        n_cmp++;
        if (bus.o_RspValid !== want) begin
          n_bad++;
          $display("FAIL b2b_order k=%0d: got %b want %b", k, bus.o_RspValid, want);
        end
      end
      advance(g);
    end
    n_cmp++;
    if (n_rsp != 8) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d want 8", n_rsp);
    end
  endtask

  task automatic test_random();
    logic [1:0]    g, ev;
    logic [DW-1:0] ed;
    for (int k = 0; k < 300; k++) begin
      if (k < 290) begin
        for (int p = 0; p < 2; p++)
          if (!hv[p] && $urandom_range(0, 1) == 1)
            load(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
      end
      present();
      @(negedge i_Clock);
      exp_rsp(ev, ed);
      n_cmp++;
      if (bus.o_ReqReady !== exp_ready()) begin
        n_bad++;
        $display("FAIL random ready @%0d: got %b want %b", cyc, bus.o_ReqReady, exp_ready());
      end
      n_cmp++;
      if (bus.o_RspValid !== ev || (ev != 2'b00 && bus.o_RspRdData !== ed)) begin
        n_bad++;
        $display("FAIL random rsp @%0d: got %b/%h want %b/%h", cyc, bus.o_RspValid, bus.o_RspRdData, ev, ed);
      end
      advance(g);
    end
  endtask

  initial begin
    salt = $urandom;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_val(i);
    hreq[0] = '0;
    hreq[1] = '0;
    test_reset();
    test_single_write_read();
    test_raw();
    test_conflict();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
